// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART system controller.
//   sys_ctrl_state_e : register-master frame FSM states
//   CMD_WR / CMD_RD  : frame opcodes (also used by the ALU-command extension)
package sys_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_PUSH = 3'd5
  } sys_ctrl_state_e;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

endpackage

// File: rtl/sys_ctrl_reg_master.sv
// Register-file initiator driven by UART RX command frames.
//   Write frame: CMD_WR, addr, data -> one WrEn pulse.
//   Read frame : CMD_RD, addr       -> RdEn pulse, then RdData is pushed into
//                                     the UART TX FIFO.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   RX_P_DATA, RX_D_VLD      received byte + one-cycle strobe
//   WrEn, RdEn, Address,     register-file request port
//   WrData
//   RdData, RdData_Valid     register-file read response
//   TX_WR_INC, TX_WR_DATA,   TX FIFO push port and full flag
//   TX_FIFO_FULL
//   Busy                     high while a read is outstanding; RX bytes dropped
//   Cmd_Err                  one-cycle pulse on bad opcode or read timeout
// All outputs are registered.
module sys_ctrl_reg_master #(
  parameter int               WIDTH      = 8,
  parameter int               ADDR       = 4,
  parameter logic [WIDTH-1:0] CMD_WR     = WIDTH'(sys_ctrl_pkg::CMD_WR),
  parameter logic [WIDTH-1:0] CMD_RD     = WIDTH'(sys_ctrl_pkg::CMD_RD),
  parameter int               RD_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_Valid,
  output logic             TX_WR_INC,
  output logic [WIDTH-1:0] TX_WR_DATA,
  input  logic             TX_FIFO_FULL,
  output logic             Busy,
  output logic             Cmd_Err
);

  import sys_ctrl_pkg::*;

  localparam int CW = $clog2(RD_TIMEOUT + 1);

  sys_ctrl_state_e state;
  logic [CW-1:0]   cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      WrEn       <= 1'b0;
      RdEn       <= 1'b0;
      TX_WR_INC  <= 1'b0;
      Cmd_Err    <= 1'b0;
      Busy       <= 1'b0;
      Address    <= '0;
      WrData     <= '0;
      TX_WR_DATA <= '0;
      cnt        <= '0;
    end else begin
      // strobes default low so every pulse lasts exactly one cycle
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_WR_INC <= 1'b0;
      Cmd_Err   <= 1'b0;
      case (state)
        IDLE: if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR)      state   <= WR_ADDR;
          else if (RX_P_DATA == CMD_RD) state   <= RD_ADDR;
          else                          Cmd_Err <= 1'b1;
        end
        // inside a frame every byte is payload, opcodes are not re-decoded
        WR_ADDR: if (RX_D_VLD) begin
          Address <= RX_P_DATA[ADDR-1:0];
          state   <= WR_DATA;
        end
        WR_DATA: if (RX_D_VLD) begin
          WrData <= RX_P_DATA;
          WrEn   <= 1'b1;
          state  <= IDLE;
        end
        RD_ADDR: if (RX_D_VLD) begin
          Address <= RX_P_DATA[ADDR-1:0];
          RdEn    <= 1'b1;
          cnt     <= '0;
          Busy    <= 1'b1;
          state   <= RD_WAIT;
        end
        // at most RD_TIMEOUT cycles are spent here before giving up
        RD_WAIT: begin
          if (RdData_Valid) begin
            TX_WR_DATA <= RdData;
            state      <= TX_PUSH;
          end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
            Cmd_Err <= 1'b1;
            Busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_PUSH: if (!TX_FIFO_FULL) begin
          TX_WR_INC <= 1'b1;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl_reg_master.sv
// Directed bench for sys_ctrl_reg_master with a behavioural register file and
// scoreboard queues for writes, TX pushes and error pulses.
module tb_sys_ctrl_reg_master;

  localparam int RD_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_vld = 1'b0;
  logic       wr_en, rd_en, tx_inc, busy, cmd_err;
  logic [3:0] addr;
  logic [7:0] wr_data, tx_data;
  logic [7:0] rd_data = '0;
  logic       rd_vld = 1'b0;
  logic       fifo_full = 1'b0;
  logic       suppress_rv = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  logic [11:0] wq[$];   // {addr, data}
  logic [7:0]  tq[$];
  int          eq[$];
  logic [7:0]  mem[16];

  sys_ctrl_reg_master #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .CLK(clk), .RST(rst),
    .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
    .WrEn(wr_en), .RdEn(rd_en), .Address(addr), .WrData(wr_data),
    .RdData(rd_data), .RdData_Valid(rd_vld),
    .TX_WR_INC(tx_inc), .TX_WR_DATA(tx_data), .TX_FIFO_FULL(fifo_full),
    .Busy(busy), .Cmd_Err(cmd_err)
  );

  always #5 clk = ~clk;

  // register file: read data returned the cycle after RdEn
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) begin
    rd_vld  <= rd_en & ~suppress_rv;
    rd_data <= mem[addr];
    if (wr_en) mem[addr] <= wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (wr_en & rd_en) chk("wr_rd_overlap", 1, 0);
    if (wr_en) begin
      if (wq.size() == 0) chk("wr_unexpected", {20'd0, addr, wr_data}, 0);
      else chk("sb_write", {20'd0, addr, wr_data}, {20'd0, wq.pop_front()});
    end
    if (tx_inc) begin
      if (tq.size() == 0) chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFF);
      else chk("sb_tx", {24'd0, tx_data}, {24'd0, tq.pop_front()});
    end
    if (cmd_err) begin
      if (eq.size() == 0) chk("err_unexpected", 1, 0);
      else begin
        void'(eq.pop_front());
        chk("sb_err", 1, 1);
      end
    end
  end

  // called at a negedge; returns at the following negedge (cycle t+1)
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {wr_en, rd_en, tx_inc, busy, cmd_err, addr, wr_data, tx_data}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    idle(3);
    chk_zero("reset_outputs");
    rst = 1'b0;
    idle(1);

    // write AA,05,3C with gaps
    wq.push_back({4'h5, 8'h3C});
    send(8'hAA); idle(2);
    send(8'h05); idle(1);
    send(8'h3C);
    chk("wr_en", wr_en, 1);
    chk("wr_addr", addr, 4'h5);
    chk("wr_data", wr_data, 8'h3C);
    chk("wr_no_err", cmd_err, 0);
    idle(1);
    chk("wr_pulse_end", wr_en, 0);

    // preload reg2 = 81
    wq.push_back({4'h2, 8'h81});
    send(8'hAA); send(8'h02); send(8'h81);
    idle(1);

    // read BB,02
    tq.push_back(8'h81);
    send(8'hBB); send(8'h02);            // t+1
    chk("rd_en", rd_en, 1);
    chk("rd_addr", addr, 4'h2);
    chk("rd_busy", busy, 1);
    idle(2);                             // t+3
    chk("rd_t3_noinc", tx_inc, 0);
    chk("rd_t3_data", tx_data, 8'h81);
    idle(1);                             // t+4
    chk("rd_t4_inc", tx_inc, 1);
    chk("rd_t4_busy", busy, 0);
    idle(1);

    // backpressure, with an AA dropped while busy
    fifo_full = 1'b1;
    tq.push_back(8'h81);
    send(8'hBB); send(8'h02);
    idle(2);                             // now in TX_PUSH
    for (int i = 0; i < 10; i++) begin
      chk("bp_noinc", tx_inc, 0);
      chk("bp_data", tx_data, 8'h81);
      chk("bp_busy", busy, 1);
      rx_data = 8'hAA;
      rx_vld  = (i == 4);
      @(negedge clk);
    end
    rx_vld = 1'b0;
    fifo_full = 1'b0;
    idle(1);
    chk("bp_inc", tx_inc, 1);
    idle(1);

    // next frame decodes normally; address truncated
    wq.push_back({4'h3, 8'h11});
    send(8'hAA); send(8'hF3);
    chk("trunc_addr", addr, 4'h3);
    send(8'h11);
    chk("trunc_wr", wr_en, 1);
    idle(1);

    // unknown opcode
    eq.push_back(1);
    send(8'h55);
    chk("bad_op_err", cmd_err, 1);
    idle(1);
    chk("bad_op_pulse", cmd_err, 0);
    chk("bad_op_idle", busy, 0);

    // read timeout
    suppress_rv = 1'b1;
    eq.push_back(1);
    send(8'hBB); send(8'h07);            // t+1
    chk("to_rd_en", rd_en, 1);
    idle(RD_TIMEOUT - 1);                // t+RD_TIMEOUT
    chk("to_pre_err", cmd_err, 0);
    chk("to_pre_busy", busy, 1);
    idle(1);
    chk("to_err", cmd_err, 1);
    chk("to_busy_clr", busy, 0);
    suppress_rv = 1'b0;
    idle(2);

    // reset mid-frame in WR_DATA
    send(8'hAA); send(8'h05);
    rst = 1'b1;
    idle(1);
    chk_zero("midframe_reset");
    rst = 1'b0;
    eq.push_back(1);
    send(8'h3C);
    chk("post_rst_err", cmd_err, 1);
    chk("post_rst_nowr", wr_en, 0);
    idle(1);

    // back-to-back: read opcode arrives in the WrEn cycle
    wq.push_back({4'h1, 8'h22});
    tq.push_back(8'h22);
    send(8'hAA); send(8'h01); send(8'h22);
    chk("b2b_wr", wr_en, 1);
    send(8'hBB); send(8'h01);
    chk("b2b_rd", rd_en, 1);
    idle(3);
    chk("b2b_tx", tx_inc, 1);
    idle(2);

    chk("wq_empty", wq.size(), 0);
    chk("tq_empty", tq.size(), 0);
    chk("eq_empty", eq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
